uart_tx_feeder: RTL
===================

Name: uart_tx_feeder

Overview:
- Byte buffer and send sequencer directly upstream of the UART TX state machine.
- Accepts bytes from the processor-side write port into a circular FIFO.
- Drains one byte at a time: presents the byte, pulses the TX start request, then waits for the TX finish pulse before releasing the next byte.
- Includes a watchdog so a stalled transmitter cannot hang the feeder.

Parameters:
- DATA_W, 8, byte width.
- ADDR_W, 4, FIFO pointer width; depth = 2**ADDR_W (16).
- TIMEOUT, 1048575, max cycles in WAIT_DONE before abort; counter width 20 bits, must be ≥1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_en  in  1  write strobe, one byte per high cycle.
- i_wr_data  in  DATA_W  byte to enqueue.
- i_clr_flags  in  1  clears o_overflow and o_timeout.
- i_tx_done  in  1  one-cycle pulse from TX FSM when frame (incl. stop/delay) is finished.
- o_tx_send  out  1  one-cycle start request to TX FSM.
- o_tx_data  out  DATA_W  byte to TX data register; stable from the o_tx_send cycle until leaving WAIT_DONE.
- o_full  out  1  count == 2**ADDR_W.
- o_empty  out  1  count == 0.
- o_count  out  ADDR_W+1  bytes held (excludes the byte in flight).
- o_busy  out  1  state != IDLE.
- o_overflow  out  1  sticky: a write was dropped.
- o_timeout  out  1  sticky: watchdog expired.

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset, sampled on a rising i_clk edge with i_rst=1:
  - wr_ptr=0, rd_ptr=0, count=0, state=IDLE, watchdog=0.
  - o_tx_data=0, o_tx_send=0, o_overflow=0, o_timeout=0.
  - FIFO contents are don't-care.
  - Reset mid-frame discards buffered and in-flight bytes. o_tx_send is low the cycle after reset.
- Write side:
  - When i_wr_en=1 and the FIFO is not full, or is full but a pop occurs the same edge: mem[wr_ptr]<=i_wr_data, wr_ptr++ (wraps modulo depth).
  - When i_wr_en=1, FIFO full, and no pop that edge: byte dropped, o_overflow<=1.
- Count: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
- Flags: o_full and o_empty are combinational from count.
- Sticky flags: i_clr_flags clears o_overflow and o_timeout. If a set condition coincides with the clear, set wins.
- FSM (registered state; outputs decoded from state):
  - IDLE: if count!=0, pop on the edge (o_tx_data<=mem[rd_ptr], rd_ptr++, count--) and go to SEND. Otherwise stay.
  - SEND: o_tx_send=1 for exactly this cycle; watchdog<=0; go to WAIT_DONE.
  - WAIT_DONE:
    - If i_tx_done=1, go to GAP.
    - Else if watchdog==TIMEOUT-1, set o_timeout and go to GAP.
    - Else watchdog++.
  - GAP: one idle cycle so the TX FSM can return to its idle state; go to IDLE.
- i_tx_done outside WAIT_DONE is ignored.
- Latency: write in cycle N to an empty, idle feeder gives o_tx_send=1 in cycle N+2.
- Back-to-back bytes: the next o_tx_send comes 3 cycles after the i_tx_done cycle (GAP, IDLE, SEND).
- o_busy=1 in SEND, WAIT_DONE and GAP.
- o_tx_data holds its last value in IDLE and GAP.

Test Plan:
- Reset, then write 0xA5 in cycle 5 → o_tx_send high in cycle 7 only, o_tx_data=0xA5, o_count=0, o_busy=1. Pulse i_tx_done in cycle 20 → o_busy=0 from cycle 22.
- Write 0x11,0x22,0x33 on consecutive cycles, bench returns i_tx_done 10 cycles after each send → three sends in order 0x11,0x22,0x33, each send 3 cycles after the previous done.
- Hold TX (no done) and write 17 bytes → 1 byte in flight, o_count=16, o_full=1, o_overflow=1 after the 18th write attempt. i_clr_flags → o_overflow=0.
- FIFO full and IDLE popping while i_wr_en=1 with 0x77 → no overflow, o_count stays 16, 0x77 drained last.
- TIMEOUT=8, send with no i_tx_done → o_timeout=1 exactly 8 cycles after entering WAIT_DONE, then GAP→IDLE, next byte sent. i_tx_done pulsed during IDLE → no effect.
- Assert i_rst during WAIT_DONE with 5 bytes queued → next cycle o_count=0, o_empty=1, o_busy=0, o_tx_data=0, no further o_tx_send.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and send sequencer sitting directly upstream of the UART TX state machine.
// Releases one byte per frame and never lets a silent transmitter stall the queue forever.
module uart_tx_feeder #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1048575
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clr_flags,
  input  logic              i_tx_done,
  output logic              o_tx_send,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_timeout
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [19:0]     WD_LAST    = 20'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_state;
  logic [19:0]       r_watchdog;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_overflow;
  logic              r_timeout;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_wd_expire;

  assign w_full      = (r_count == FULL_COUNT);
  assign w_empty     = (r_count == '0);
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  // A pop on the same edge frees a slot, so a write to a full FIFO is still taken.
  assign w_push      = i_wr_en && (!w_full || w_pop);
  assign w_drop      = i_wr_en && !w_push;
  assign w_wd_expire = (r_state == S_WAIT) && !i_tx_done && (r_watchdog == WD_LAST);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + COUNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - COUNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_watchdog <= '0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          r_watchdog <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (i_tx_done || w_wd_expire) begin
            r_state <= S_GAP;
          end else begin
            r_watchdog <= r_watchdog + 20'd1;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clr_flags) begin
        r_overflow <= 1'b0;
      end
      if (w_wd_expire) begin
        r_timeout <= 1'b1;
      end else if (i_clr_flags) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign o_tx_send  = (r_state == S_SEND);
  assign o_tx_data  = r_tx_data;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_busy     = (r_state != S_IDLE);
  assign o_overflow = r_overflow;
  assign o_timeout  = r_timeout;

endmodule
